// File: rtl/pcie_rx_pkg.sv
// -----------------------------------------------------------------------------
// pcie_rx_pkg
//   Shared types and constants for the 128b/130b receive-side block sequencer:
//   block classification, ordered-set first-symbol codes, sync-header codes,
//   sequencer states and the PIPE width decode.
// -----------------------------------------------------------------------------
package pcie_rx_pkg;

    typedef enum logic [1:0] {
        BT_NONE = 2'd0,
        BT_DATA = 2'd1,
        BT_SKP  = 2'd2,
        BT_OS   = 2'd3
    } block_type_e;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_BLOCK = 2'd1,
        ST_OFF   = 2'd2
    } seq_state_e;

    localparam int unsigned SYMS_PER_BLOCK_C = 16;

    localparam logic [7:0] EIEOS_SYM_C = 8'h00;
    localparam logic [7:0] SKP_SYM_C   = 8'hAA;
    localparam logic [7:0] EIOS_SYM_C  = 8'h66;

    localparam logic [1:0] SH_DATA = 2'b10;
    localparam logic [1:0] SH_OS   = 2'b01;

    // Symbols carried per beat for a PIPE width; 0 flags an unsupported width.
    function automatic logic [2:0] width_to_bytes(input logic [5:0] width);
        logic [2:0] nbytes;
        case (width)
            6'd8:    nbytes = 3'd1;
            6'd16:   nbytes = 3'd2;
            6'd32:   nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/block_counter.sv
// -----------------------------------------------------------------------------
// block_counter
//   Symbol position within the current 128b/130b block.
//   Ports:
//     clk_i        lane clock
//     rst_ni       synchronous active-low reset
//     clear_i      force the count back to the start of a block
//     step_i       a beat of the current block was consumed
//     bytes_i      symbols per beat (1/2/4)
//     boundary_o   the beat being consumed completes the block
//     mid_block_o  the count is inside a block (next beat is not a start)
// -----------------------------------------------------------------------------
module block_counter #(
    parameter int unsigned SYMS_PER_BLOCK = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       step_i,
    input  logic [2:0] bytes_i,
    output logic       boundary_o,
    output logic       mid_block_o
);

    logic [4:0] sym_cnt_q;
    logic [4:0] sym_cnt_d;
    logic [5:0] sym_sum;

    // One extra bit so 15 + 4 cannot alias back into range.
    assign sym_sum     = {1'b0, sym_cnt_q} + {3'b000, bytes_i};
    assign boundary_o  = (sym_sum == 6'(SYMS_PER_BLOCK));
    assign mid_block_o = (sym_cnt_q != 5'd0);

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        if (clear_i) begin
            sym_cnt_d = 5'd0;
        end else if (step_i) begin
            sym_cnt_d = boundary_o ? 5'd0 : sym_sum[4:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sym_cnt_q <= 5'd0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
        end
    end

endmodule

// File: rtl/descrambler_seq.sv
// -----------------------------------------------------------------------------
// descrambler_seq
//   Per-lane 128b/130b block sequencer between the PIPE receive interface and
//   the descrambler. Tracks block framing, classifies each block from its sync
//   header and first symbol, and drives the descrambler's LFSR reseed, per-byte
//   advance and bypass controls.
//   Ports:
//     clk, reset (sync, active-low)
//     turnOff            scrambling disabled, forces bypass
//     PIPEWIDTH          8/16/32 bit beat width
//     PIPEDataValid      beat carries data
//     PIPEStartBlock     first beat of a block
//     PIPESyncHeader     10 = data, 01 = ordered set (start beats only)
//     PIPEData           received symbols, byte 0 earliest
//     patternReset       LFSR reseed request (registered)
//     advance            per-byte LFSR advance (combinational, same beat)
//     bypass             pass data through unmodified (combinational)
//     blockType          0 none, 1 data, 2 SKP, 3 other ordered set
//     blockErr           one-cycle framing error pulse (registered)
//     locked             block alignment held (registered)
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_ALIGN | hunting for a valid start beat; LFSR held in reseed
//   ST_BLOCK | aligned, counting symbols through each block
//   ST_OFF   | scrambling disabled; everything bypassed
// -----------------------------------------------------------------------------
module descrambler_seq
    import pcie_rx_pkg::*;
#(
    parameter int unsigned SYMS_PER_BLOCK = SYMS_PER_BLOCK_C,
    parameter logic [7:0]  EIEOS_SYM      = EIEOS_SYM_C,
    parameter logic [7:0]  SKP_SYM        = SKP_SYM_C,
    parameter logic [7:0]  EIOS_SYM       = EIOS_SYM_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        turnOff,
    input  logic [5:0]  PIPEWIDTH,
    input  logic        PIPEDataValid,
    input  logic        PIPEStartBlock,
    input  logic [1:0]  PIPESyncHeader,
    input  logic [31:0] PIPEData,
    output logic        patternReset,
    output logic [3:0]  advance,
    output logic        bypass,
    output logic [1:0]  blockType,
    output logic        blockErr,
    output logic        locked
);

    seq_state_e  state_q;
    block_type_e blk_type_q;
    logic        eieos_q;
    logic [5:0]  width_q;
    logic        pattern_reset_q;
    logic        block_err_q;
    logic        locked_q;

    logic [2:0]  beat_bytes;
    logic [3:0]  lane_mask;
    logic [7:0]  sym0;
    logic        hdr_legal;
    logic        start_beat;
    block_type_e start_type;
    logic        start_eieos;
    block_type_e cur_type;

    logic        boundary;
    logic        mid_block;

    logic        in_align;
    logic        in_block;
    logic        align_accept;
    logic        align_hdr_err;
    logic        blk_err;
    logic        blk_start;
    logic        last_beat;
    logic        ctr_step;
    logic        ctr_clear;

    logic        unused_data;

    assign sym0        = PIPEData[7:0];
    assign unused_data = ^PIPEData[31:8];

    assign beat_bytes = width_to_bytes(PIPEWIDTH);
    assign hdr_legal  = (PIPESyncHeader == SH_DATA) || (PIPESyncHeader == SH_OS);
    assign start_beat = PIPEDataValid && PIPEStartBlock;

    always_comb begin
        lane_mask = 4'b0000;
        case (beat_bytes)
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0011;
            3'd4:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    // Classification of the block whose first beat is on the bus right now.
    always_comb begin
        start_type  = BT_NONE;
        start_eieos = 1'b0;
        if (PIPESyncHeader == SH_DATA) begin
            start_type = BT_DATA;
        end else if (PIPESyncHeader == SH_OS) begin
            start_eieos = (sym0 == EIEOS_SYM);
            if (sym0 == SKP_SYM) begin
                start_type = BT_SKP;
            end else if (sym0 == EIOS_SYM) begin
                // EIOS behaves like any other ordered set: LFSR steps, data bypassed.
                start_type = BT_OS;
            end else begin
                start_type = BT_OS;
            end
        end
    end

    block_counter #(
        .SYMS_PER_BLOCK(SYMS_PER_BLOCK)
    ) u_block_counter (
        .clk_i       (clk),
        .rst_ni      (reset),
        .clear_i     (ctr_clear),
        .step_i      (ctr_step),
        .bytes_i     (beat_bytes),
        .boundary_o  (boundary),
        .mid_block_o (mid_block)
    );

    // turnOff outranks every state, so both gates include it.
    assign in_align = (state_q == ST_ALIGN) && !turnOff;
    assign in_block = (state_q == ST_BLOCK) && !turnOff;

    assign align_accept  = in_align && start_beat && hdr_legal && (beat_bytes != 3'd0);
    assign align_hdr_err = in_align && start_beat && !hdr_legal;

    // Width is checked every cycle in BLOCK, not just on valid beats.
    assign blk_err = in_block && (
                         (PIPEWIDTH != width_q)
                      || (start_beat && mid_block)
                      || (PIPEDataValid && !PIPEStartBlock && !mid_block)
                      || (start_beat && !mid_block && !hdr_legal));

    assign blk_start = in_block && start_beat && !mid_block && !blk_err;
    assign last_beat = in_block && PIPEDataValid && boundary && !blk_err;

    // The start beat accepted in ALIGN already counts as the block's first beat.
    assign ctr_step  = align_accept || (in_block && PIPEDataValid && !blk_err);
    assign ctr_clear = blk_err || (!in_block && !align_accept);

    always_comb begin
        cur_type = BT_NONE;
        if (align_accept) begin
            cur_type = start_type;
        end else if (in_block) begin
            if (mid_block) begin
                cur_type = blk_type_q;
            end else if (start_beat && hdr_legal) begin
                cur_type = start_type;
            end
        end
    end

    always_comb begin
        advance = 4'b0000;
        if (in_block && PIPEDataValid && (cur_type == BT_DATA || cur_type == BT_OS)) begin
            advance = lane_mask;
        end
    end

    assign bypass    = !in_block || (cur_type == BT_SKP) || (cur_type == BT_OS);
    assign blockType = cur_type;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_ALIGN;
            blk_type_q      <= BT_NONE;
            eieos_q         <= 1'b0;
            width_q         <= 6'd0;
            pattern_reset_q <= 1'b1;
            block_err_q     <= 1'b0;
            locked_q        <= 1'b0;
        end else begin
            block_err_q     <= 1'b0;
            pattern_reset_q <= 1'b0;
            if (turnOff) begin
                state_q  <= ST_OFF;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ALIGN: begin
                        if (align_accept) begin
                            state_q    <= ST_BLOCK;
                            locked_q   <= 1'b1;
                            blk_type_q <= start_type;
                            eieos_q    <= start_eieos;
                            width_q    <= PIPEWIDTH;
                        end else begin
                            pattern_reset_q <= 1'b1;
                            locked_q        <= 1'b0;
                            block_err_q     <= align_hdr_err;
                        end
                    end
                    ST_BLOCK: begin
                        if (blk_err) begin
                            // Any pending EIEOS reseed is dropped; ALIGN reseeds anyway.
                            state_q         <= ST_ALIGN;
                            locked_q        <= 1'b0;
                            block_err_q     <= 1'b1;
                            pattern_reset_q <= 1'b1;
                        end else begin
                            if (blk_start) begin
                                blk_type_q <= start_type;
                                eieos_q    <= start_eieos;
                            end
                            if (last_beat && eieos_q) begin
                                pattern_reset_q <= 1'b1;
                            end
                        end
                    end
                    ST_OFF: begin
                        state_q         <= ST_ALIGN;
                        locked_q        <= 1'b0;
                        pattern_reset_q <= 1'b1;
                    end
                    default: begin
                        state_q         <= ST_ALIGN;
                        locked_q        <= 1'b0;
                        pattern_reset_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Reseed is also requested combinationally while reset is held low.
    assign patternReset = pattern_reset_q || !reset;
    assign blockErr     = block_err_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_descrambler_seq.sv
module tb_descrambler_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        turnOff;
    logic [5:0]  PIPEWIDTH;
    logic        PIPEDataValid;
    logic        PIPEStartBlock;
    logic [1:0]  PIPESyncHeader;
    logic [31:0] PIPEData;
    logic        patternReset;
    logic [3:0]  advance;
    logic        bypass;
    logic [1:0]  blockType;
    logic        blockErr;
    logic        locked;

    logic        rst_sel = 1'b0;
    logic        off_sel = 1'b0;
    logic [5:0]  w_sel   = 6'd32;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    descrambler_seq dut (
        .clk            (clk),
        .reset          (reset),
        .turnOff        (turnOff),
        .PIPEWIDTH      (PIPEWIDTH),
        .PIPEDataValid  (PIPEDataValid),
        .PIPEStartBlock (PIPEStartBlock),
        .PIPESyncHeader (PIPESyncHeader),
        .PIPEData       (PIPEData),
        .patternReset   (patternReset),
        .advance        (advance),
        .bypass         (bypass),
        .blockType      (blockType),
        .blockErr       (blockErr),
        .locked         (locked)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] adv, input logic byp,
                            input logic [1:0] bt);
        chk({tag, ".advance"},   32'(advance),   32'(adv));
        chk({tag, ".bypass"},    32'(bypass),    32'(byp));
        chk({tag, ".blockType"}, 32'(blockType), 32'(bt));
    endtask

    task automatic chk_reg(input string tag, input logic pr, input logic err, input logic lk);
        chk({tag, ".patternReset"}, 32'(patternReset), 32'(pr));
        chk({tag, ".blockErr"},     32'(blockErr),     32'(err));
        chk({tag, ".locked"},       32'(locked),       32'(lk));
    endtask

    // Inputs change on the falling edge; comparisons follow 1 time unit later.
    task automatic beat(input logic v, input logic sb, input logic [1:0] sh, input logic [7:0] d0);
        @(negedge clk);
        reset          = rst_sel;
        turnOff        = off_sel;
        PIPEWIDTH      = w_sel;
        PIPEDataValid  = v;
        PIPEStartBlock = sb;
        PIPESyncHeader = sh;
        PIPEData       = {24'hC3A5F0, d0};
        #1;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 2'b00, 8'h00);
    endtask

    // One whole block; from_align marks a block whose start beat is seen in ALIGN.
    task automatic blk(input string tag, input int n, input logic [1:0] sh, input logic [7:0] d0,
                       input logic from_align, input logic [3:0] adv, input logic byp,
                       input logic [1:0] bt);
        for (int i = 0; i < n; i++) begin
            if (i == 0) beat(1'b1, 1'b1, sh, d0);
            else        beat(1'b1, 1'b0, 2'b00, 8'h5C);
            if (i == 0 && from_align) begin
                chk({tag, "[0].advance"},      32'(advance),      32'h0);
                chk({tag, "[0].bypass"},       32'(bypass),       32'h1);
                chk({tag, "[0].patternReset"}, 32'(patternReset), 32'h1);
            end else begin
                chk_beat($sformatf("%s[%0d]", tag, i), adv, byp, bt);
                if (i == 0) chk({tag, "[0].blockErr"}, 32'(blockErr), 32'h0);
            end
            if (i > 0) chk_reg($sformatf("%s[%0d]", tag, i), 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        turnOff        = 1'b0;
        PIPEWIDTH      = 6'd32;
        PIPEDataValid  = 1'b0;
        PIPEStartBlock = 1'b0;
        PIPESyncHeader = 2'b00;
        PIPEData       = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_beat("rst", 4'h0, 1'b1, 2'd0);
        chk_reg("rst", 1'b1, 1'b0, 1'b0);
        rst_sel = 1'b1;
        idle();

        // Width 32 data stream
        blk("d32a", 4, 2'b10, 8'h12, 1'b1, 4'hF, 1'b0, 2'd1);
        blk("d32b", 4, 2'b10, 8'h34, 1'b0, 4'hF, 1'b0, 2'd1);

        // Width change while locked
        w_sel = 6'd8;
        idle();
        idle();
        chk_reg("wchg", 1'b1, 1'b1, 1'b0);
        idle();
        chk("wchg.pulse", 32'(blockErr), 32'h0);

        // Width 8: data, SKP, data
        blk("d8a", 16, 2'b10, 8'h11, 1'b1, 4'h1, 1'b0, 2'd1);
        blk("skp", 16, 2'b01, 8'hAA, 1'b0, 4'h0, 1'b1, 2'd2);
        blk("d8b", 16, 2'b10, 8'h22, 1'b0, 4'h1, 1'b0, 2'd1);

        // turnOff at a block boundary, switch to width 16
        off_sel = 1'b1;
        w_sel   = 6'd16;
        idle();
        chk_beat("off", 4'h0, 1'b1, 2'd0);
        off_sel = 1'b0;
        idle();
        chk_reg("off", 1'b0, 1'b0, 1'b0);
        idle();
        chk("off.exit.patternReset", 32'(patternReset), 32'h1);

        // Width 16: data then EIEOS
        blk("d16", 8, 2'b10, 8'h33, 1'b1, 4'h3, 1'b0, 2'd1);
        blk("eieos", 8, 2'b01, 8'h00, 1'b0, 4'h3, 1'b1, 2'd3);
        idle();
        chk("eieos.pr", 32'(patternReset), 32'h1);
        chk("eieos.err", 32'(blockErr), 32'h0);
        idle();
        chk("eieos.pr_end", 32'(patternReset), 32'h0);

        // Three-cycle valid gap inside a width-16 data block
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    idle();
                    chk_beat($sformatf("gap%0d", g), 4'h0, 1'b0, 2'd1);
                end
            end
            if (i == 0) beat(1'b1, 1'b1, 2'b10, 8'h44);
            else        beat(1'b1, 1'b0, 2'b00, 8'h5C);
            chk_beat($sformatf("gapblk[%0d]", i), 4'h3, 1'b0, 2'd1);
        end
        beat(1'b1, 1'b1, 2'b10, 8'h55);
        chk_beat("gap.next", 4'h3, 1'b0, 2'd1);
        chk_reg("gap.next", 1'b0, 1'b0, 1'b1);

        // turnOff mid-block, then realign at width 32
        off_sel = 1'b1;
        beat(1'b1, 1'b0, 2'b00, 8'h5C);
        chk_beat("toff", 4'h0, 1'b1, 2'd0);
        off_sel = 1'b0;
        w_sel   = 6'd32;
        idle();
        chk_reg("toff", 1'b0, 1'b0, 1'b0);
        idle();
        chk("toff.exit.patternReset", 32'(patternReset), 32'h1);
        beat(1'b1, 1'b1, 2'b10, 8'h66);
        chk("realign.advance", 32'(advance), 32'h0);
        chk("realign.bypass", 32'(bypass), 32'h1);

        // Start on beat 2 of a width-32 block
        beat(1'b1, 1'b1, 2'b10, 8'h77);
        chk("realign.locked", 32'(locked), 32'h1);
        idle();
        chk_reg("midstart", 1'b1, 1'b1, 1'b0);
        idle();
        chk("midstart.pulse", 32'(blockErr), 32'h0);

        // Illegal header in ALIGN
        beat(1'b1, 1'b1, 2'b11, 8'h00);
        idle();
        chk_reg("hdr11", 1'b1, 1'b1, 1'b0);
        idle();
        chk("hdr11.pulse", 32'(blockErr), 32'h0);

        // Missing start on the beat after a boundary
        blk("d32c", 4, 2'b10, 8'h88, 1'b1, 4'hF, 1'b0, 2'd1);
        beat(1'b1, 1'b0, 2'b00, 8'h5C);
        idle();
        chk_reg("nostart", 1'b1, 1'b1, 1'b0);

        // Illegal header on a start beat while locked
        idle();
        blk("d32d", 4, 2'b10, 8'h8A, 1'b1, 4'hF, 1'b0, 2'd1);
        beat(1'b1, 1'b1, 2'b00, 8'h00);
        idle();
        chk_reg("hdr00", 1'b1, 1'b1, 1'b0);

        // Reset for one cycle mid-block
        beat(1'b1, 1'b1, 2'b10, 8'h99);
        beat(1'b1, 1'b0, 2'b00, 8'h5C);
        chk("rst2.pre.locked", 32'(locked), 32'h1);
        rst_sel = 1'b0;
        beat(1'b1, 1'b0, 2'b00, 8'h5C);
        chk("rst2.low.patternReset", 32'(patternReset), 32'h1);
        rst_sel = 1'b1;
        idle();
        chk_beat("rst2", 4'h0, 1'b1, 2'd0);
        chk_reg("rst2", 1'b1, 1'b0, 1'b0);
        idle();
        chk("rst2.hold.patternReset", 32'(patternReset), 32'h1);
        beat(1'b1, 1'b1, 2'b10, 8'hAB);
        chk("rst2.acc.patternReset", 32'(patternReset), 32'h1);
        beat(1'b1, 1'b0, 2'b00, 8'h5C);
        chk_reg("rst2.lock", 1'b0, 1'b0, 1'b1);
        chk_beat("rst2.lock", 4'hF, 1'b0, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
